// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite constants and loader state encoding
package axil_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] WSTRB_ALL = 4'hF;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;
  localparam int BYTE_STRIDE = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_BRESP, S_READ, S_RDATA, S_DONE
  } loader_state_e;
endpackage

// File: rtl/axil_master_loader_if.sv
// axil_master_loader_if: AXI4-Lite bus between the loader and the perceptron slave
interface axil_master_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_write_channel.sv
// axil_write_channel: tracks independent AW/W handshakes of one write, strobes when both are accepted
module axil_write_channel (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic accepted
);
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  always_comb begin
    awvalid = active & ~aw_done_q;
    wvalid = active & ~w_done_q;
    accepted = active & (aw_done_q | awready) & (w_done_q | wready);
    aw_done_d = active & ~accepted & (aw_done_q | awready);
    w_done_d = active & ~accepted & (w_done_q | wready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
endmodule

// File: rtl/axil_master_loader.sv
// axil_master_loader: writes a block of source words over AXI-Lite, then reads back one result register
module axil_master_loader
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 10
) (
  input  logic s_axi_aclk,
  input  logic s_axi_areset,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0] word_count,
  input  logic [ADDR_WIDTH-1:0] result_addr,
  output logic [CNT_WIDTH-1:0] src_addr,
  output logic src_en,
  input  logic [DATA_WIDTH-1:0] src_data,
  axil_master_loader_if.master m_axi,
  output logic busy,
  output logic done,
  output logic [DATA_WIDTH-1:0] result,
  output logic error
);
  loader_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, raddr_q, raddr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, i_q, i_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, result_q, result_d;
  logic error_q, error_d, wr_accepted;
  axil_write_channel u_wr (
    .clk(s_axi_aclk), .rst(s_axi_areset), .active(state_q == S_WRITE),
    .awready(m_axi.awready), .wready(m_axi.wready),
    .awvalid(m_axi.awvalid), .wvalid(m_axi.wvalid), .accepted(wr_accepted)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    raddr_d = raddr_q;
    cnt_d = cnt_q;
    i_d = i_q;
    wdata_d = wdata_q;
    result_d = result_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (start) begin
        base_d = base_addr;
        cnt_d = word_count;
        raddr_d = result_addr;
        error_d = 1'b0;
        i_d = '0;
        state_d = (word_count != '0) ? S_FETCH : S_READ;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        wdata_d = src_data;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = wr_accepted ? S_BRESP : S_WRITE;
      S_BRESP: if (m_axi.bvalid) begin
        error_d = error_q | (m_axi.bresp != RESP_OKAY);
        i_d = (i_q == cnt_q - CNT_WIDTH'(1)) ? i_q : i_q + CNT_WIDTH'(1);
        state_d = (i_q == cnt_q - CNT_WIDTH'(1)) ? S_READ : S_FETCH;
      end
      S_READ: state_d = m_axi.arready ? S_RDATA : S_READ;
      S_RDATA: if (m_axi.rvalid) begin
        result_d = m_axi.rdata;
        error_d = error_q | (m_axi.rresp != RESP_OKAY);
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q <= S_IDLE;
      base_q <= '0;
      raddr_q <= '0;
      cnt_q <= '0;
      i_q <= '0;
      wdata_q <= '0;
      result_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      raddr_q <= raddr_d;
      cnt_q <= cnt_d;
      i_q <= i_d;
      wdata_q <= wdata_d;
      result_q <= result_d;
      error_q <= error_d;
    end
  end
  // Outputs decode from registered state, so an asynchronous reset drops them at once
  assign src_en = state_q == S_FETCH;
  assign src_addr = i_q;
  assign m_axi.awaddr = base_q + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(BYTE_STRIDE);
  assign m_axi.awprot = AXI_PROT_DEFAULT;
  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = WSTRB_ALL;
  assign m_axi.bready = state_q == S_BRESP;
  assign m_axi.araddr = raddr_q;
  assign m_axi.arprot = AXI_PROT_DEFAULT;
  assign m_axi.arvalid = state_q == S_READ;
  assign m_axi.rready = state_q == S_RDATA;
  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = state_q == S_DONE;
  assign result = result_q;
  assign error = error_q;
endmodule

// File: tb/tb_axil_master_loader.sv
// tb_axil_master_loader: table-driven jobs against a responsive AXI-Lite slave model, plus reset/start corner cases
module tb_axil_master_loader;
  import axil_pkg::*;
  localparam int AW = 32, DW = 32, CW = 10;
  logic clk = 0, rst = 0, start = 0;
  logic [AW-1:0] base_addr = '0, result_addr = '0;
  logic [CW-1:0] word_count = '0, src_addr;
  logic src_en, busy, done, error;
  logic [DW-1:0] src_data, result;
  axil_master_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();
  axil_master_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .result_addr(result_addr), .src_addr(src_addr), .src_en(src_en),
    .src_data(src_data), .m_axi(m), .busy(busy), .done(done), .result(result), .error(error)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [AW-1:0] base;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    int awd;
    int wd;
    int errw;
    logic [1:0] rresp;
    logic exp_err;
    int mode;
  } vec_t;

  logic [DW-1:0] mem [1024];
  int aw_delay = 0, w_delay = 0, err_word = -1, b_base = 0;
  logic [DW-1:0] rdata_cfg = '0;
  logic [1:0] rresp_cfg = 2'b00;
  logic [AW-1:0] aw_log[$], ar_log[$];
  logic [DW-1:0] w_log[$];
  int b_cnt = 0, done_cnt = 0, stab_err = 0, aw_cnt = 0, w_cnt = 0;
  logic aw_pend = 0, w_pend = 0;
  logic [AW-1:0] aw_hold;
  logic [DW-1:0] w_hold;
  int checks = 0, errors = 0;

  always @(posedge clk) src_data <= src_en ? mem[src_addr] : 32'h0BAD_F00D;

  always @(negedge clk) begin
    if (rst) begin
      m.awready = 0; m.wready = 0; m.bvalid = 0; m.bresp = 0;
      m.arready = 0; m.rvalid = 0; m.rdata = 0; m.rresp = 0;
      aw_cnt = 0; w_cnt = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (aw_pend && m.awvalid && m.awaddr !== aw_hold) stab_err++;
      if (w_pend && m.wvalid && m.wdata !== w_hold) stab_err++;
      m.awready = m.awvalid && aw_cnt >= aw_delay;
      aw_cnt = m.awvalid ? aw_cnt + 1 : 0;
      m.wready = m.wvalid && w_cnt >= w_delay;
      w_cnt = m.wvalid ? w_cnt + 1 : 0;
      m.bvalid = m.bready;
      m.bresp = (b_cnt - b_base == err_word) ? RESP_SLVERR : RESP_OKAY;
      m.arready = m.arvalid;
      m.rvalid = m.rready;
      m.rdata = rdata_cfg;
      m.rresp = rresp_cfg;
      if (m.awvalid && m.awready) aw_log.push_back(m.awaddr);
      if (m.wvalid && m.wready) w_log.push_back(m.wdata);
      if (m.bvalid) b_cnt++;
      if (m.arvalid && m.arready) ar_log.push_back(m.araddr);
      if (done) done_cnt++;
      aw_pend = m.awvalid && !m.awready;
      aw_hold = m.awaddr;
      w_pend = m.wvalid && !m.wready;
      w_hold = m.wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [CW-1:0] c, input logic [AW-1:0] b, input logic [AW-1:0] r);
    @(negedge clk);
    base_addr = b; word_count = c; result_addr = r; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ab, wb, arb, db, n;
    ab = aw_log.size(); wb = w_log.size(); arb = ar_log.size(); db = done_cnt; b_base = b_cnt;
    aw_delay = v.awd; w_delay = v.wd; err_word = v.errw; rdata_cfg = v.rdata; rresp_cfg = v.rresp;
    do_start(v.cnt, v.base, v.raddr);
    chk($sformatf("v%0d busy_after_start", idx), 32'(busy), 1);
    chk($sformatf("v%0d error_cleared", idx), 32'(error), 0);
    if (v.mode == 1) begin
      n = 0;
      while (!m.bready && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("v%0d bready_seen", idx), 32'(m.bready), 1);
      base_addr = 32'h0000_0900; word_count = 5; result_addr = 32'h70; start = 1;
      @(negedge clk);
      start = 0;
    end
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    chk($sformatf("v%0d done_seen", idx), 32'(done), 1);
    chk($sformatf("v%0d busy_at_done", idx), 32'(busy), 0);
    chk($sformatf("v%0d result", idx), result, v.rdata);
    chk($sformatf("v%0d error", idx), 32'(error), 32'(v.exp_err));
    if (v.mode == 2) begin
      base_addr = 32'h0000_0C00; word_count = 1; start = 1;
      @(negedge clk);
      start = 0;
      chk($sformatf("v%0d start_in_done_ignored", idx), 32'(busy), 0);
    end
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d done_pulses", idx), done_cnt - db, 1);
    chk($sformatf("v%0d done_low", idx), 32'(done), 0);
    chk($sformatf("v%0d aw_count", idx), aw_log.size() - ab, 32'(v.cnt));
    chk($sformatf("v%0d w_count", idx), w_log.size() - wb, 32'(v.cnt));
    for (int k = 0; k < int'(v.cnt); k++) begin
      if (ab + k < aw_log.size()) chk($sformatf("v%0d awaddr%0d", idx, k), aw_log[ab+k], v.base + 32'(4 * k));
      if (wb + k < w_log.size()) chk($sformatf("v%0d wdata%0d", idx, k), w_log[wb+k], mem[k]);
    end
    chk($sformatf("v%0d ar_count", idx), ar_log.size() - arb, 1);
    if (arb < ar_log.size()) chk($sformatf("v%0d araddr", idx), ar_log[arb], v.raddr);
    chk($sformatf("v%0d stable_valids", idx), stab_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t clean;
    int n;
    vecs[0] = '{10'd3, 32'h0000_0100, 32'h40, 32'hDEAD_BEEF, 0, 0, -1, RESP_OKAY, 1'b0, 0};
    vecs[1] = '{10'd2, 32'h0000_0200, 32'h44, 32'h1234_5678, 3, 0, -1, RESP_OKAY, 1'b0, 0};
    vecs[2] = '{10'd2, 32'h0000_0300, 32'h48, 32'hCAFE_F00D, 0, 3, -1, RESP_OKAY, 1'b0, 0};
    vecs[3] = '{10'd0, 32'h0000_0400, 32'h4C, 32'h0BAD_CAFE, 0, 0, -1, RESP_OKAY, 1'b0, 0};
    vecs[4] = '{10'd3, 32'h0000_0500, 32'h50, 32'h55AA_55AA, 1, 2, 1, RESP_OKAY, 1'b1, 2};
    vecs[5] = '{10'd3, 32'hFFFF_FFF8, 32'h54, 32'hA1B2_C3D4, 0, 0, -1, RESP_OKAY, 1'b0, 0};
    vecs[6] = '{10'd2, 32'h0000_0700, 32'h60, 32'h1357_9BDF, 0, 0, -1, RESP_OKAY, 1'b0, 1};
    vecs[7] = '{10'd1, 32'h0000_0800, 32'h58, 32'h8765_4321, 2, 2, -1, RESP_SLVERR, 1'b1, 0};
    clean = '{10'd2, 32'h0000_0B00, 32'h84, 32'hFEED_FACE, 0, 0, -1, RESP_OKAY, 1'b0, 0};
    mem[0] = 32'hA0A0_A0A0;
    mem[1] = 32'hB1B1_B1B1;
    mem[2] = 32'hC2C2_C2C2;
    for (int k = 3; k < 1024; k++) mem[k] = 32'h5000_0000 + 32'(k);
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst awvalid", 32'(m.awvalid), 0);
    chk("rst wvalid", 32'(m.wvalid), 0);
    chk("rst bready", 32'(m.bready), 0);
    chk("rst arvalid", 32'(m.arvalid), 0);
    chk("rst rready", 32'(m.rready), 0);
    chk("rst src_en", 32'(src_en), 0);
    chk("rst src_addr", 32'(src_addr), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst error", 32'(error), 0);
    chk("rst result", result, 0);
    chk("awprot", 32'(m.awprot), 0);
    chk("arprot", 32'(m.arprot), 0);
    chk("wstrb", 32'(m.wstrb), 32'hF);
    rst = 0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    aw_delay = 20; w_delay = 0; err_word = -1; b_base = b_cnt;
    do_start(10'd3, 32'h0000_0A00, 32'h80);
    n = 0;
    while (!m.awvalid && n < 50) begin @(negedge clk); n++; end
    chk("midwrite awvalid_seen", 32'(m.awvalid), 1);
    #2 rst = 1;
    #1;
    chk("midrst awvalid", 32'(m.awvalid), 0);
    chk("midrst wvalid", 32'(m.wvalid), 0);
    chk("midrst bready", 32'(m.bready), 0);
    chk("midrst arvalid", 32'(m.arvalid), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst src_en", 32'(src_en), 0);
    chk("midrst src_addr", 32'(src_addr), 0);
    chk("midrst error", 32'(error), 0);
    chk("midrst result", result, 0);
    @(negedge clk);
    rst = 0;
    run_vec(clean, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_master_loader.md
Name: axil_master_loader

Overview:
- AXI4-Lite initiator: drives the AXI-Lite register port of the perceptron from a local source memory.
- On a start pulse it writes WORD_COUNT 32-bit words (image pixels or weights) to consecutive slave addresses from base_addr.
- After the writes it reads one result register and returns its value with a done pulse and a sticky error flag.
- It sits between the image/weight buffer and the perceptron's S_AXI slave port.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width and source word width.
- CNT_WIDTH, 10, width of word_count and src_addr (784-pixel MNIST image fits).

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; ignored unless the block is idle.
- base_addr  in  ADDR_WIDTH  first write address; sampled on start.
- word_count  in  CNT_WIDTH  number of words to write; sampled on start.
- result_addr  in  ADDR_WIDTH  address of the final read; sampled on start.
- src_addr  out  CNT_WIDTH  source memory word index.
- src_en  out  1  source read enable; data is valid on src_data exactly 1 cycle later.
- src_data  in  DATA_WIDTH  source memory read data.
- M_AXI_awaddr/awprot/awvalid out, awready in: AW channel; awprot = 3'b000.
- M_AXI_wdata/wstrb/wvalid out, wready in: W channel; wstrb = 4'hF.
- M_AXI_bresp in (2), bvalid in, bready out: B channel.
- M_AXI_araddr/arprot/arvalid out, arready in: AR channel; arprot = 3'b000.
- M_AXI_rdata in, rresp in (2), rvalid in, rready out: R channel.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the result is captured.
- result  out  DATA_WIDTH  rdata of the final read; held until the next done.
- error  out  1  sticky: any bresp or rresp != OKAY during the job; cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - All valid/ready outputs, src_en, busy, done and error are 0.
  - result, src_addr and the internal counter are 0.
  - Reset mid-transaction aborts immediately and drops valids; no completion is attempted.
- IDLE:
  - start=1 latches base_addr, word_count and result_addr; clears error and the counter i.
  - Next state is FETCH if word_count != 0, otherwise READ.
- FETCH:
  - src_en=1, src_addr=i; next state WAIT.
- WAIT:
  - Captures src_data into the write data register.
  - Drives awaddr = base + (i<<2) and wdata.
  - Asserts awvalid and wvalid together; next state WRITE.
- WRITE:
  - Each valid is held until its own handshake (valid & ready).
  - AW and W complete independently, in any order or in the same cycle; track each with an aw_done/w_done flag.
  - Address and data are stable while valid is high.
  - When both are done: bready=1, next state BRESP.
- BRESP:
  - Wait for bvalid. bresp != 2'b00 sets error.
  - If i == count-1, next state READ; otherwise i <= i+1 and next state FETCH.
  - Only one write is outstanding at a time.
- READ:
  - arvalid=1, araddr=result_addr, held until arready; then rready=1 and next state RDATA.
- RDATA:
  - Wait for rvalid; result <= rdata. rresp != OKAY sets error.
  - Next state DONE.
- DONE:
  - done=1 for one cycle, busy=0 in the same cycle; next state IDLE.
  - A start in this cycle is ignored; start is accepted from IDLE only.
- Address arithmetic:
  - Byte stride is 4. Addresses wrap modulo 2^ADDR_WIDTH with no error.
  - The counter compares against count-1 in CNT_WIDTH bits; word_count=2^CNT_WIDTH-1 is the largest supported job.
- Latency: minimum per write word is 4 cycles (FETCH, WAIT, WRITE with immediate readies, BRESP with immediate bvalid).
- start asserted while busy: no effect on the job in progress.

Decomposition:
- Shared package axil_pkg holds:
  - AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
  - WSTRB_ALL, AXI_PROT_DEFAULT, BYTE_STRIDE=4.
  - the loader state enum.
- The perceptron AXI-Lite slave uses the same package.
- One sub-module is natural: axil_write_channel, which handles the AW/W independent-handshake tracking and returns a single "write accepted" strobe.
- The read path stays inline.

Test Plan:
- Basic job: word_count=3, base=32'h0000_0100, src={A,B,C}, readies always high, result register at 0x40 returns 32'hDEAD_BEEF.
  - Expect writes to 0x100, 0x104, 0x108 with A, B, C; then a read at 0x40.
  - Expect result=DEADBEEF, done pulsed once, error=0.
- Skewed readies: awready delayed 3 cycles, wready immediate; then the reverse.
  - Expect each valid held until its handshake and each word written exactly once.
  - Expect awaddr/wdata stable while their valid is high.
- Zero count: word_count=0.
  - Expect no AW/W activity; the AR read is issued directly and done asserts.
- Error: the slave returns bresp=2'b10 on word 1 of 3.
  - Expect all 3 writes and the read still performed, and error=1 at done.
  - Expect a new start to clear error.
- Reset mid-WRITE: assert s_axi_areset while awvalid=1.
  - Expect all outputs to go to their reset values in the same cycle.
  - Expect a later start to run a clean job from word 0.
- Start while busy: pulse start during BRESP with different parameters.
  - Expect them ignored and the original job to complete with its original addresses.
